// File: rtl/exu_pkg.sv
// Shared opcodes, FSM state type and flag bit positions for the execution stage.
package exu_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_PASSB = 4'd8;
  localparam logic [3:0] OP_MUL   = 4'd9;

  typedef enum logic {S_RUN, S_MUL} exuState_e;

  // Flag vector layout is {V, N, Z}
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 2;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding mux: select 0 (or any out-of-range value) keeps the register operand.
module fwd_mux #(
  parameter int DATA_W   = 32,
  parameter int FWD_SRCS = 2,
  parameter int SEL_W    = $clog2(FWD_SRCS + 1)
) (
  input  logic [DATA_W-1:0]          iReg,
  input  logic [FWD_SRCS*DATA_W-1:0] iTaps,
  input  logic [SEL_W-1:0]           iSel,
  output logic [DATA_W-1:0]          oData
);

  always_comb begin
    oData = iReg;
    for (int k = 1; k <= FWD_SRCS; k++) begin
      if (int'(iSel) == k) oData = iTaps[(k-1)*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/exu_pipe_stage.sv
// Execution stage: forwarded operands, single-cycle ALU, multi-cycle multiply,
// registered result slot with valid/ready on both sides and flag commit.
module exu_pipe_stage
  import exu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int FWD_SRCS = 2,
  parameter int MUL_LAT  = 3,
  parameter int SEL_W    = $clog2(FWD_SRCS + 1)
) (
  input  logic                       iClk,
  input  logic                       iRst_n,
  input  logic                       iValid,
  output logic                       oReady,
  input  logic [3:0]                 iOp,
  input  logic [DATA_W-1:0]          iSrc0,
  input  logic [DATA_W-1:0]          iSrc1,
  input  logic [DATA_W-1:0]          iImm,
  input  logic                       iUseImm,
  input  logic [FWD_SRCS*DATA_W-1:0] iFwdData,
  input  logic [SEL_W-1:0]           iFwdSel0,
  input  logic [SEL_W-1:0]           iFwdSel1,
  input  logic [2:0]                 iFlagEn,
  input  logic [4:0]                 iWriteAddr,
  input  logic                       iWriteEn,
  input  logic                       iFlush,
  output logic                       oValid,
  input  logic                       iReady,
  output logic [DATA_W-1:0]          oResult,
  output logic [4:0]                 oWriteAddr,
  output logic                       oWriteEn,
  output logic                       oZeroFlag,
  output logic                       oNegativeFlag,
  output logic                       oOverflowFlag,
  output logic                       oBusy
);

  localparam int SHAMT_W = $clog2(DATA_W);
  localparam int CNT_W   = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam int MSB     = DATA_W - 1;

  exuState_e stateQ, stateD;
  logic [CNT_W-1:0]  cntQ;
  logic [DATA_W-1:0] mulAQ, mulBQ, prod;
  logic [4:0]        mulAddrQ;
  logic              mulWeQ;
  logic [2:0]        mulFlagEnQ, flagsQ;

  logic [DATA_W-1:0] opA, opBFwd, opB, aluRes, sumAdd, sumSub, ldRes;
  logic              aluV, canLoad, accept, aluLoad, mulStart, mulDone, load;
  logic [2:0]        ldFlags, ldEn;
  logic [4:0]        ldAddr;
  logic              ldWe;

  fwd_mux #(.DATA_W(DATA_W), .FWD_SRCS(FWD_SRCS), .SEL_W(SEL_W)) uFwdA (
    .iReg  (iSrc0),
    .iTaps (iFwdData),
    .iSel  (iFwdSel0),
    .oData (opA)
  );

  fwd_mux #(.DATA_W(DATA_W), .FWD_SRCS(FWD_SRCS), .SEL_W(SEL_W)) uFwdB (
    .iReg  (iSrc1),
    .iTaps (iFwdData),
    .iSel  (iFwdSel1),
    .oData (opBFwd)
  );

  assign opB    = iUseImm ? iImm : opBFwd;
  assign sumAdd = opA + opB;
  assign sumSub = opA - opB;
  assign prod   = mulAQ * mulBQ;

  always_comb begin
    aluRes = opB;
    aluV   = 1'b0;
    case (iOp)
      OP_ADD: begin
        aluRes = sumAdd;
        aluV   = (opA[MSB] == opB[MSB]) && (sumAdd[MSB] != opA[MSB]);
      end
      OP_SUB: begin
        aluRes = sumSub;
        aluV   = (opA[MSB] != opB[MSB]) && (sumSub[MSB] != opA[MSB]);
      end
      OP_AND:  aluRes = opA & opB;
      OP_OR:   aluRes = opA | opB;
      OP_XOR:  aluRes = opA ^ opB;
      OP_SLL:  aluRes = opA << opB[SHAMT_W-1:0];
      OP_SRL:  aluRes = opA >> opB[SHAMT_W-1:0];
      OP_SRA:  aluRes = $unsigned($signed(opA) >>> opB[SHAMT_W-1:0]);
      default: aluRes = opB;
    endcase
  end

  // Handshake and slot-load decode; ALU and multiply loads are exclusive by state.
  always_comb begin
    canLoad  = !oValid || iReady;
    oReady   = (stateQ == S_RUN) && canLoad;
    oBusy    = (stateQ == S_MUL);
    accept   = iValid && oReady;
    aluLoad  = accept && (iOp != OP_MUL);
    mulStart = accept && (iOp == OP_MUL);
    mulDone  = (stateQ == S_MUL) && (cntQ == '0) && canLoad;
    load     = aluLoad || mulDone;
    ldRes    = mulDone ? prod : aluRes;
    ldAddr   = mulDone ? mulAddrQ : iWriteAddr;
    ldWe     = mulDone ? mulWeQ : iWriteEn;
    ldEn     = mulDone ? mulFlagEnQ : iFlagEn;
    ldFlags          = '0;
    ldFlags[FLAG_Z]  = (ldRes == '0);
    ldFlags[FLAG_N]  = ldRes[MSB];
    ldFlags[FLAG_V]  = mulDone ? 1'b0 : aluV;
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      S_RUN: if (mulStart) stateD = S_MUL;
      S_MUL: if (mulDone) stateD = S_RUN;
    endcase
    if (iFlush) stateD = S_RUN;
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) stateQ <= S_RUN;
    else         stateQ <= stateD;
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      cntQ       <= '0;
      mulAQ      <= '0;
      mulBQ      <= '0;
      mulAddrQ   <= '0;
      mulWeQ     <= 1'b0;
      mulFlagEnQ <= '0;
      oValid     <= 1'b0;
      oResult    <= '0;
      oWriteAddr <= '0;
      oWriteEn   <= 1'b0;
      flagsQ     <= '0;
    end else if (iFlush) begin
      oValid <= 1'b0;
      cntQ   <= '0;
    end else begin
      if (mulStart) begin
        mulAQ      <= opA;
        mulBQ      <= opB;
        mulAddrQ   <= iWriteAddr;
        mulWeQ     <= iWriteEn;
        mulFlagEnQ <= iFlagEn;
        cntQ       <= CNT_W'(MUL_LAT - 1);
      end else if ((stateQ == S_MUL) && (cntQ != '0)) begin
        cntQ <= cntQ - 1'b1;
      end
      if (load) begin
        oValid     <= 1'b1;
        oResult    <= ldRes;
        oWriteAddr <= ldAddr;
        oWriteEn   <= ldWe;
        flagsQ     <= (flagsQ & ~ldEn) | (ldFlags & ldEn);
      end else if (oValid && iReady) begin
        oValid <= 1'b0;
      end
    end
  end

  assign oZeroFlag     = flagsQ[FLAG_Z];
  assign oNegativeFlag = flagsQ[FLAG_N];
  assign oOverflowFlag = flagsQ[FLAG_V];

endmodule

// File: tb/tb_exu_pipe_stage.sv
// Scoreboard bench for exu_pipe_stage: directed ops push expected results, a
// negedge monitor pops and compares on every result handshake.
module tb_exu_pipe_stage;
  import exu_pkg::*;

  logic        iClk, iRst_n, iValid, oReady, iUseImm, iFlush, oValid, iReady;
  logic [3:0]  iOp;
  logic [31:0] iSrc0, iSrc1, iImm, oResult;
  logic [63:0] iFwdData;
  logic [1:0]  iFwdSel0, iFwdSel1;
  logic [2:0]  iFlagEn;
  logic [4:0]  iWriteAddr, oWriteAddr;
  logic        iWriteEn, oWriteEn, oZeroFlag, oNegativeFlag, oOverflowFlag, oBusy;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  addr;
    logic        we;
    logic [2:0]  flg;
  } expT;

  expT expQ[$];
  int  nTot = 0;
  int  nBad = 0;

  exu_pipe_stage #(.DATA_W(32), .FWD_SRCS(2), .MUL_LAT(3)) dut (
    .iClk          (iClk),
    .iRst_n        (iRst_n),
    .iValid        (iValid),
    .oReady        (oReady),
    .iOp           (iOp),
    .iSrc0         (iSrc0),
    .iSrc1         (iSrc1),
    .iImm          (iImm),
    .iUseImm       (iUseImm),
    .iFwdData      (iFwdData),
    .iFwdSel0      (iFwdSel0),
    .iFwdSel1      (iFwdSel1),
    .iFlagEn       (iFlagEn),
    .iWriteAddr    (iWriteAddr),
    .iWriteEn      (iWriteEn),
    .iFlush        (iFlush),
    .oValid        (oValid),
    .iReady        (iReady),
    .oResult       (oResult),
    .oWriteAddr    (oWriteAddr),
    .oWriteEn      (oWriteEn),
    .oZeroFlag     (oZeroFlag),
    .oNegativeFlag (oNegativeFlag),
    .oOverflowFlag (oOverflowFlag),
    .oBusy         (oBusy)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTot++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] flags();
    return {oOverflowFlag, oNegativeFlag, oZeroFlag};
  endfunction

  always @(negedge iClk) begin
    expT e;
    if (iRst_n && oValid && iReady) begin
      if (expQ.size() == 0) begin
        nTot++;
        nBad++;
        $display("FAIL unexpected_output actual=%h required=none", oResult);
      end else begin
        e = expQ.pop_front();
        check("result", oResult, e.res);
        check("waddr", 32'(oWriteAddr), 32'(e.addr));
        check("wen", 32'(oWriteEn), 32'(e.we));
        check("flags", 32'(flags()), 32'(e.flg));
      end
    end
  end

  task automatic pushExp(input logic [31:0] er, input logic [4:0] wa, input logic we,
                         input logic [2:0] ef);
    expT e;
    e.res = er; e.addr = wa; e.we = we; e.flg = ef;
    expQ.push_back(e);
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic useImm, input logic [1:0] s0,
                       input logic [1:0] s1, input logic [2:0] fe, input logic [4:0] wa,
                       input logic we);
    iOp = op; iSrc0 = a; iSrc1 = b; iImm = imm; iUseImm = useImm;
    iFwdSel0 = s0; iFwdSel1 = s1; iFlagEn = fe; iWriteAddr = wa; iWriteEn = we;
    iValid = 1'b1;
  endtask

  // Presents one op, waits for acceptance, returns 1ns after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic useImm, input logic [1:0] s0,
                       input logic [1:0] s1, input logic [2:0] fe, input logic [4:0] wa,
                       input logic we, input logic push, input logic [31:0] er,
                       input logic [2:0] ef);
    bit ok = 1'b0;
    drive(op, a, b, imm, useImm, s0, s1, fe, wa, we);
    if (push) pushExp(er, wa, we, ef);
    for (int i = 0; i < 20; i++) begin
      @(negedge iClk);
      if (oReady) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      nTot++;
      nBad++;
      $display("FAIL accept_timeout actual=oReady_low required=accept");
    end
    @(posedge iClk); #1;
    iValid = 1'b0;
  endtask

  initial begin
    iRst_n = 1'b0; iValid = 1'b0; iReady = 1'b1; iFlush = 1'b0;
    iOp = OP_ADD; iSrc0 = '0; iSrc1 = '0; iImm = '0; iUseImm = 1'b0;
    iFwdSel0 = '0; iFwdSel1 = '0; iFlagEn = '0; iWriteAddr = '0; iWriteEn = 1'b0;
    iFwdData = {32'h0000_0055, 32'h0000_0100};
    repeat (2) @(posedge iClk);
    #1 iRst_n = 1'b1;
    check("rst_valid", 32'(oValid), 0);
    check("rst_result", oResult, 0);
    check("rst_flags", 32'(flags()), 0);
    check("rst_busy", 32'(oBusy), 0);
    check("rst_ready", 32'(oReady), 1);

    // ADD overflow, visible one cycle after accept
    issue(OP_ADD, 32'h7FFF_FFFF, 32'h1, 0, 0, 0, 0, 3'b111, 5'd3, 1, 1, 32'h8000_0000, 3'b110);
    check("add_lat_valid", 32'(oValid), 1);
    check("add_lat_result", oResult, 32'h8000_0000);
    issue(OP_SUB, 32'h11, 0, 0, 1, 2, 0, 3'b111, 5'd4, 1, 1, 32'h55, 3'b000);
    issue(OP_ADD, 32'h11, 0, 0, 1, 3, 0, 3'b001, 5'd5, 1, 1, 32'h11, 3'b000);
    issue(OP_ADD, 32'h11, 32'h999, 0, 0, 1, 2, 3'b000, 5'd6, 0, 1, 32'h155, 3'b000);
    issue(OP_AND, 32'hF0F0, 32'hFF00, 0, 0, 0, 0, 3'b000, 5'd7, 1, 1, 32'hF000, 3'b000);
    issue(OP_OR, 32'hF0F0, 32'h0F00, 0, 0, 0, 0, 3'b000, 5'd8, 1, 1, 32'hFFF0, 3'b000);
    issue(OP_XOR, 32'hAAAA, 32'hAAAA, 0, 0, 0, 0, 3'b001, 5'd9, 1, 1, 32'h0, 3'b001);
    issue(OP_SLL, 32'h1, 32'h24, 0, 0, 0, 0, 3'b000, 5'd10, 1, 1, 32'h10, 3'b001);
    issue(OP_SRL, 32'h8000_0000, 32'd31, 0, 0, 0, 0, 3'b000, 5'd11, 1, 1, 32'h1, 3'b001);
    issue(OP_SRA, 32'h8000_0000, 32'd4, 0, 0, 0, 0, 3'b010, 5'd12, 1, 1, 32'hF800_0000,
          3'b011);
    issue(4'hF, 32'h5, 32'h1234, 0, 0, 0, 0, 3'b111, 5'd13, 1, 1, 32'h1234, 3'b000);
    issue(OP_SUB, 32'h8000_0000, 32'h1, 0, 0, 0, 0, 3'b111, 5'd14, 1, 1, 32'h7FFF_FFFF,
          3'b100);
    issue(OP_PASSB, 32'h77, 32'h0, 0, 0, 0, 0, 3'b001, 5'd15, 1, 1, 32'h0, 3'b101);

    // Multiply: three stall cycles, result at accept+3
    issue(OP_MUL, 32'h1_0000, 32'h1_0001, 0, 0, 0, 0, 3'b111, 5'd16, 1, 1, 32'h1_0000, 3'b000);
    check("mul_ready0", 32'(oReady), 0);
    check("mul_busy", 32'(oBusy), 1);
    @(posedge iClk); #1 check("mul_ready1", 32'(oReady), 0);
    @(posedge iClk); #1 check("mul_ready2", 32'(oReady), 0);
    check("mul_notyet", 32'(oValid), 0);
    @(posedge iClk); #1 check("mul_valid", 32'(oValid), 1);
    check("mul_idle", 32'(oBusy), 0);

    // Backpressure: slot full, downstream stalled for 4 cycles
    issue(OP_ADD, 32'hFFFF_FFF0, 32'h6, 0, 0, 0, 0, 3'b111, 5'd17, 1, 1, 32'hFFFF_FFF6,
          3'b010);
    iReady = 1'b0;
    drive(OP_ADD, 32'd7, 32'd8, 0, 0, 0, 0, 3'b111, 5'd18, 1);
    pushExp(32'd15, 5'd18, 1, 3'b000);
    for (int i = 0; i < 4; i++) begin
      @(posedge iClk); #1;
      check("bp_ready", 32'(oReady), 0);
      check("bp_result", oResult, 32'hFFFF_FFF6);
      check("bp_flags", 32'(flags()), 32'(3'b010));
    end
    iReady = 1'b1;
    @(posedge iClk); #1;
    check("bp_resume", oResult, 32'd15);
    for (int k = 1; k <= 4; k++) begin
      drive(OP_ADD, 32'(k), 32'(k), 0, 0, 0, 0, 3'b000, 5'(k), 1);
      pushExp(32'(2 * k), 5'(k), 1, 3'b000);
      @(posedge iClk); #1;
      check("stream_result", oResult, 32'(2 * k));
    end
    iValid = 1'b0;

    issue(OP_SUB, 32'h0, 32'h1, 0, 0, 0, 0, 3'b111, 5'd19, 1, 1, 32'hFFFF_FFFF, 3'b010);
    @(posedge iClk); #1;

    // Flush while idle drops the presented op
    iFlush = 1'b1;
    drive(OP_ADD, 32'h1, 32'h1, 0, 0, 0, 0, 3'b111, 5'd20, 1);
    @(posedge iClk); #1;
    iFlush = 1'b0; iValid = 1'b0;
    check("flush_drop_valid", 32'(oValid), 0);
    check("flush_drop_flags", 32'(flags()), 32'(3'b010));

    // Flush in S_MUL at cnt=1
    issue(OP_MUL, 32'd3, 32'd4, 0, 0, 0, 0, 3'b111, 5'd21, 1, 0, 0, 0);
    @(posedge iClk); #1 iFlush = 1'b1;
    @(posedge iClk); #1 iFlush = 1'b0;
    check("flush_mul_valid", 32'(oValid), 0);
    check("flush_mul_ready", 32'(oReady), 1);
    check("flush_mul_busy", 32'(oBusy), 0);
    check("flush_mul_flags", 32'(flags()), 32'(3'b010));
    repeat (4) @(posedge iClk);
    #1 check("flush_mul_quiet", 32'(oValid), 0);

    // Reset mid-multiply
    issue(OP_MUL, 32'd5, 32'd5, 0, 0, 0, 0, 3'b111, 5'd22, 1, 0, 0, 0);
    @(posedge iClk); #1 iRst_n = 1'b0;
    @(posedge iClk); #1 iRst_n = 1'b1;
    check("rst2_valid", 32'(oValid), 0);
    check("rst2_result", oResult, 0);
    check("rst2_waddr", 32'(oWriteAddr), 0);
    check("rst2_wen", 32'(oWriteEn), 0);
    check("rst2_flags", 32'(flags()), 0);
    check("rst2_busy", 32'(oBusy), 0);
    check("rst2_ready", 32'(oReady), 1);
    issue(OP_MUL, 32'd6, 32'd7, 0, 0, 0, 0, 3'b111, 5'd23, 1, 1, 32'd42, 3'b000);
    repeat (6) @(posedge iClk);
    #1 check("queue_empty", 32'(expQ.size()), 0);

    $display("test done: total=%0d bad=%0d", nTot, nBad);
    $finish;
  end

endmodule
